// File: rtl/fsqrt_nr_seq.sv
// Sequential single-precision sqrt / reciprocal-sqrt using a table seed and
// Newton-Raphson refinement of 1/sqrt(m), with IEEE rounding of the result.
module fsqrt_nr_seq #(
    parameter int ITER = 3,
    parameter int WF   = 32
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] d,
    input  logic        op,
    input  logic [1:0]  rm,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] s,
    output logic        nv,
    output logic        dz,
    output logic        busy
);

    localparam int W  = WF + 3;
    localparam int RW = WF - 23;
    localparam logic [W-1:0] THREE = W'(3) << WF;

    typedef enum logic [2:0] {ST_IDLE, ST_NORM, ST_ITER, ST_ROUND, ST_DONE} state_t;

    state_t             state;
    logic [31:0]        d_r;
    logic               op_r;
    logic [1:0]         rm_r;
    logic [W-1:0]       m_r, y_r;
    logic signed [9:0]  ex_r;
    logic [2:0]         cnt;

    function automatic logic [W-1:0] mulq(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input int unsigned sh);
        return W'(({{W{1'b0}}, a} * {{W{1'b0}}, b}) >> sh);
    endfunction

    // Q0.16 approximations of 1/sqrt at the midpoint of each quarter of [1,4)
    function automatic logic [15:0] seed(input logic [3:0] idx);
        case (idx)
            4'd4:    return 16'hF15C;
            4'd5:    return 16'hDA51;
            4'd6:    return 16'hC8D3;
            4'd7:    return 16'hBAF5;
            4'd8:    return 16'hAF9E;
            4'd9:    return 16'hA61D;
            4'd10:   return 16'h9E01;
            4'd11:   return 16'h96FB;
            4'd12:   return 16'h90D0;
            4'd13:   return 16'h8B59;
            4'd14:   return 16'h8675;
            4'd15:   return 16'h820C;
            default: return 16'hFFFF;
        endcase
    endfunction

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    logic        is_nan, is_inf, is_zero, special, sp_nv, sp_dz;
    logic [31:0] sp_s;

    always_comb begin
        is_nan  = (&d[30:23]) & (|d[22:0]);
        is_inf  = (&d[30:23]) & ~(|d[22:0]);
        is_zero = ~(|d[30:0]);
        special = is_nan | is_inf | is_zero | d[31];
        sp_s    = '0;
        sp_nv   = 1'b0;
        sp_dz   = 1'b0;
        if (is_nan || (d[31] && !is_zero)) begin
            sp_s  = 32'h7FC00000;
            sp_nv = 1'b1;
        end else if (is_zero) begin
            if (op) begin
                sp_s  = {d[31], 8'hFF, 23'h0};
                sp_dz = 1'b1;
            end else begin
                sp_s = d;
            end
        end else if (is_inf) begin
            sp_s = op ? 32'h0 : 32'h7F800000;
        end
    end

    logic [23:0]       sig24, sig;
    logic [4:0]        lz;
    logic signed [9:0] e_unb, e_even, he, ex_n;
    logic [W-1:0]      m_n, y_n;

    always_comb begin
        sig24 = {|d_r[30:23], d_r[22:0]};
        lz    = '0;
        for (int unsigned i = 0; i < 24; i++)
            if (sig24[i]) lz = 5'(23 - i);
        sig   = sig24 << lz;
        e_unb = ((d_r[30:23] == 8'd0) ? -10'sd126 : ($signed({2'b00, d_r[30:23]}) - 10'sd127))
                - $signed({5'b0, lz});
        m_n   = W'(sig) << (WF - 23);
        if (e_unb[0]) m_n = m_n << 1;
        e_even = e_unb - $signed({9'b0, e_unb[0]});
        he     = e_even >>> 1;
        ex_n   = op_r ? -he : he;
        y_n    = W'(seed(m_n[WF+1 -: 4])) << (WF - 16);
    end

    logic [W-1:0] t1, t2, t3, y_it;

    always_comb begin
        t1   = mulq(y_r, y_r, WF);
        t2   = mulq(m_r, t1, WF);
        t3   = THREE - t2;
        y_it = mulq(y_r, t3, WF + 1);
    end

    logic [W-1:0]      q, qn;
    logic              lo, g, rb, st, inc;
    logic [23:0]       kept;
    logic [RW-1:0]     rest;
    logic [24:0]       rnd;
    logic signed [9:0] exp_r;
    logic [31:0]       s_n;

    // Residual bits within 1/8 ulp of a grid point are snapped onto it, so
    // exact results stay exact in every rounding mode despite truncation noise.
    always_comb begin
        q    = op_r ? y_r : mulq(m_r, y_r, WF);
        lo   = ~q[WF];
        qn   = lo ? (q << 1) : q;
        kept = qn[WF -: 24];
        rest = qn[RW-1:0];
        g    = rest[RW-1];
        rb   = rest[RW-2];
        st   = |rest[RW-3:0];
        if (&rest[RW-1 -: 3])
            inc = 1'b1;
        else if (~|rest[RW-1 -: 3])
            inc = 1'b0;
        else begin
            case (rm_r)
                2'b00:   inc = g & (rb | st | kept[0]);
                2'b10:   inc = 1'b1;
                default: inc = 1'b0;
            endcase
        end
        rnd   = {1'b0, kept} + 25'(inc);
        exp_r = ex_r - $signed({9'b0, lo}) + $signed({9'b0, rnd[24]}) + 10'sd127;
        s_n   = {1'b0, exp_r[7:0], rnd[24] ? 23'h0 : rnd[22:0]};
    end

    logic unused_bits;
    assign unused_bits = ^{qn[W-1:WF+1], exp_r[9:8], rnd[23], d_r[31]};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= ST_IDLE;
            d_r       <= '0;
            op_r      <= 1'b0;
            rm_r      <= '0;
            m_r       <= '0;
            y_r       <= '0;
            ex_r      <= '0;
            cnt       <= '0;
            s         <= '0;
            nv        <= 1'b0;
            dz        <= 1'b0;
            out_valid <= 1'b0;
        end else if (flush && state != ST_IDLE) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid && !flush) begin
                    d_r  <= d;
                    op_r <= op;
                    rm_r <= rm;
                    if (special) begin
                        s         <= sp_s;
                        nv        <= sp_nv;
                        dz        <= sp_dz;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    m_r   <= m_n;
                    y_r   <= y_n;
                    ex_r  <= ex_n;
                    cnt   <= 3'(ITER - 1);
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    y_r <= y_it;
                    if (cnt == 3'd0) state <= ST_ROUND;
                    else             cnt   <= cnt - 3'd1;
                end
                ST_ROUND: begin
                    s         <= s_n;
                    nv        <= 1'b0;
                    dz        <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsqrt_nr_seq.sv
// Directed-vector bench for fsqrt_nr_seq: results, flags, latency, backpressure,
// flush and asynchronous reset behaviour.
module tb_fsqrt_nr_seq;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] d = '0;
    logic        op = 1'b0;
    logic [1:0]  rm = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] s;
    logic        nv, dz, busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fsqrt_nr_seq #(.ITER(3), .WF(32)) dut (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
        .d(d), .op(op), .rm(rm), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .nv(nv), .dz(dz), .busy(busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Presents one operand, waits (bounded) for out_valid, returns the result
    // and latency in edges counted from the accepting edge, then consumes it.
    task automatic do_op(input logic [31:0] a, input logic o, input logic [1:0] r,
                         output logic [31:0] res, output logic [1:0] flags, output int lat);
        d = a; op = o; rm = r; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = s;
        flags = {nv, dz};
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (s !== 32'h0) begin bad++; $display("FAIL reset_s got=%h want=00000000", s); end
        total++; if ({nv, dz} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {nv, dz}); end
        clrn = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_idle got=%b want=1", in_ready); end
    endtask

    task automatic test_normal();
        logic [31:0] va [17] = '{32'h40800000, 32'h40000000, 32'h40000000, 32'h40000000,
                                 32'h40000000, 32'h40800000, 32'h00000001, 32'h41100000,
                                 32'h41100000, 32'h3F800000, 32'h40000000, 32'h40000000,
                                 32'h00400000, 32'h3E800000, 32'h3F000000, 32'h40100000,
                                 32'h40100000};
        logic        vo [17] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 1, 0, 1, 1};
        logic [1:0]  vr [17] = '{0, 0, 3, 2, 1, 0, 0, 2, 3, 2, 0, 2, 0, 3, 0, 0, 3};
        logic [31:0] ve [17] = '{32'h40000000, 32'h3FB504F3, 32'h3FB504F3, 32'h3FB504F4,
                                 32'h3FB504F3, 32'h3F000000, 32'h1A3504F3, 32'h40400000,
                                 32'h40400000, 32'h3F800000, 32'h3F3504F3, 32'h3F3504F4,
                                 32'h1FB504F3, 32'h40000000, 32'h3F3504F3, 32'h3F2AAAAB,
                                 32'h3F2AAAAA};
        logic [31:0] res;
        logic [1:0]  fl;
        int          lat;
        for (int i = 0; i < 17; i++) begin
            do_op(va[i], vo[i], vr[i], res, fl, lat);
            total++; if (res !== ve[i]) begin bad++; $display("FAIL normal[%0d]_s d=%h op=%b rm=%b got=%h want=%h", i, va[i], vo[i], vr[i], res, ve[i]); end
            total++; if (fl !== 2'b00) begin bad++; $display("FAIL normal[%0d]_flags got=%b want=00", i, fl); end
            total++; if (lat !== 6) begin bad++; $display("FAIL normal[%0d]_latency got=%0d want=6", i, lat); end
        end
    endtask

    task automatic test_special();
        logic [31:0] va [9] = '{32'hBF800000, 32'h00000000, 32'h80000000, 32'h7F800000,
                                32'h7F800000, 32'h7FA00000, 32'h80000000, 32'hFF800000,
                                32'h80000001};
        logic        vo [9] = '{0, 1, 0, 1, 0, 0, 1, 1, 0};
        logic [31:0] ve [9] = '{32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h00000000,
                                32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000,
                                32'h7FC00000};
        logic [1:0]  vf [9] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b10};
        logic [31:0] res;
        logic [1:0]  fl;
        int          lat;
        for (int i = 0; i < 9; i++) begin
            do_op(va[i], vo[i], 2'b00, res, fl, lat);
            total++; if (res !== ve[i]) begin bad++; $display("FAIL special[%0d]_s d=%h op=%b got=%h want=%h", i, va[i], vo[i], res, ve[i]); end
            total++; if (fl !== vf[i]) begin bad++; $display("FAIL special[%0d]_flags got=%b want=%b", i, fl, vf[i]); end
            total++; if (lat !== 1) begin bad++; $display("FAIL special[%0d]_latency got=%0d want=1", i, lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic [1:0]  fl;
        int          lat;
        int          wait_cnt;
        out_ready = 1'b0;
        d = 32'h41100000; op = 1'b0; rm = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 40) begin @(posedge clk); #1; wait_cnt++; end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_timeout got=%b want=1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (s !== 32'h40400000 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold[%0d] s=%h valid=%b want s=40400000 valid=1", i, s, out_valid); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        do_op(32'h3E800000, 1'b1, 2'b00, res, fl, lat);
        total++; if (res !== 32'h40000000 || lat !== 6) begin bad++; $display("FAIL b2b_first s=%h lat=%0d want 40000000/6", res, lat); end
        do_op(32'h41800000, 1'b0, 2'b00, res, fl, lat);
        total++; if (res !== 32'h40800000 || lat !== 6) begin bad++; $display("FAIL b2b_second s=%h lat=%0d want 40800000/6", res, lat); end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic [1:0]  fl;
        int          lat;
        logic        seen;
        d = 32'h40800000; op = 1'b0; rm = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL flush_idle in_ready=%b busy=%b want 1/0", in_ready, busy); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_valid got=%b want=0", seen); end

        flush = 1'b1; in_valid = 1'b1; d = 32'h40800000;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_blocks_accept busy=%b in_ready=%b want 0/1", busy, in_ready); end

        d = 32'h40800000; op = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        clrn = 1'b0;
        #1;
        total++; if (s !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || {nv, dz} !== 2'b00)
            begin bad++; $display("FAIL clrn_abort s=%h valid=%b in_ready=%b busy=%b flags=%b want reset values", s, out_valid, in_ready, busy, {nv, dz}); end
        @(posedge clk); #3;
        clrn = 1'b1;
        @(posedge clk); #1;
        do_op(32'h40000000, 1'b0, 2'b00, res, fl, lat);
        total++; if (res !== 32'h3FB504F3 || fl !== 2'b00 || lat !== 6) begin bad++; $display("FAIL after_clrn s=%h flags=%b lat=%0d want 3FB504F3/00/6", res, fl, lat); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_back_to_back();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fsqrt_nr_seq.md
FSQRT_NR_SEQ -- requirements
Module: fsqrt_nr_seq

Interface
REQ-001 Parameter ITER, default 3: Newton-Raphson iteration count; legal range 1..4.
REQ-002 Parameter WF, default 32: working fraction width in bits; legal range 28..40.
REQ-003 clk  in  1  clock; every register updates on the rising edge.
REQ-004 clrn  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  operand valid.
REQ-006 in_ready  out  1  block can accept an operand.
REQ-007 d  in  32  IEEE-754 single-precision operand.
REQ-008 op  in  1  0 = sqrt(d), 1 = rsqrt(d), i.e. 1/sqrt(d).
REQ-009 rm  in  2  rounding mode: 00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero.
REQ-010 flush  in  1  synchronous abort of the operation in flight.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 s  out  32  single-precision result.
REQ-014 nv  out  1  invalid-operation flag, qualified by out_valid.
REQ-015 dz  out  1  divide-by-zero flag, qualified by out_valid.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, NORM, ITER, ROUND and DONE.
REQ-018 in_ready SHALL equal (state==IDLE); an operand is accepted on a clock edge where in_valid & in_ready; d, op and rm are registered on acceptance.
REQ-019 Special operands (NaN, ±INF, ±0, negative) SHALL go IDLE->DONE with latency 1: out_valid rises on the edge after acceptance.
REQ-020 Special results, sqrt: NaN or any negative nonzero -> 0x7FC00000 with nv=1; +INF -> +INF; ±0 -> ±0.
REQ-021 Special results, rsqrt: NaN or negative nonzero -> 0x7FC00000 with nv=1; +INF -> +0; ±0 -> ±INF with dz=1.
REQ-022 Finite positive operands SHALL follow IDLE->NORM->ITER (ITER cycles)->ROUND->DONE; latency from acceptance to out_valid = ITER+3 cycles.
REQ-023 NORM, denormal inputs: normalize with a leading-zero shift so the mantissa m lies in [1,2), and adjust the unbiased exponent E by the shift amount.
REQ-024 NORM, odd E: set m = 2m and E = E-1, so m lies in [1,4) and E is even.
REQ-025 NORM, seed: y0 ≈ 1/sqrt(m), taken from a 16-entry constant table indexed by the top 4 bits of m (including the integer bit), held at WF bits.
REQ-026 ITER: each cycle computes y = y*(3 - m*y*y)/2; intermediate products are truncated to WF fraction bits and an iteration counter decrements from ITER-1 to 0.
REQ-027 ROUND, sqrt: result q = m*y, exponent E/2; q lies in [1,2).
REQ-028 ROUND, rsqrt: result q = y, exponent -E/2; if q<1, shift q left 1 and decrement the exponent.
REQ-029 ROUND: round q to 24 bits using guard, round and sticky bits per rm; if the carry reaches 2.0, renormalize and increment the exponent; rebias by +127.
REQ-030 Range: no overflow, underflow or denormal output is possible for sqrt or rsqrt; no logic is required for these cases.
REQ-031 Accuracy with default parameters: results SHALL be correctly rounded for exact squares and powers of two, and within 1 ulp of the correctly rounded value otherwise.
REQ-032 DONE: out_valid=1; s, nv and dz are held stable until out_ready=1, which returns the FSM to IDLE on that edge. Any number of stall cycles is legal.
REQ-033 flush=1 in any state other than IDLE: next state IDLE, out_valid=0, the result is discarded; flush in IDLE has no effect.
REQ-034 flush takes priority over out_ready and over acceptance; no operand is accepted on a cycle where flush is high.
REQ-035 For a normal result, nv=0 and dz=0.

Reset
REQ-036 While clrn=0: state=IDLE, in_ready=1, out_valid=0, busy=0, s=0x00000000, nv=0, dz=0, and the iteration counter and datapath registers are 0.
REQ-037 Reset asserted during any state SHALL abort the operation; after release, the first accepted operand is processed normally.

Verification
REQ-038 sqrt 0x40800000 (4.0), RNE -> s=0x40000000, nv=0, dz=0; out_valid 6 cycles after acceptance with ITER=3.
REQ-039 sqrt 0x40000000 (2.0): RNE -> 0x3FB504F3, RTZ -> 0x3FB504F3, toward +inf -> 0x3FB504F4.
REQ-040 rsqrt 0x40800000 -> 0x3F000000; sqrt 0x00000001 (minimum denormal), RNE -> 0x1A3504F3.
REQ-041 Special cases, each with latency 1: sqrt 0xBF800000 -> 0x7FC00000, nv=1; rsqrt 0x00000000 -> 0x7F800000, dz=1; sqrt 0x80000000 -> 0x80000000.
REQ-042 Backpressure: hold out_ready=0 for 5 cycles in DONE -> s stable, in_ready=0; after out_ready=1 -> IDLE next cycle, and back-to-back operations are accepted.
REQ-043 Flush at ITER cycle 2 -> out_valid never asserts and IDLE is reached next cycle. Repeat the same test with clrn pulsed instead of flush -> all outputs at reset values, and the following operation is correct.
